instr_prefetch_queue: RTL and testbench

Instruction prefetch queue between the instruction memory port and the pipelined core's fetch stage. It issues sequential word fetches ahead of the core, buffers up to DEPTH returned instructions with their PCs, and presents them in order to the core's Fetch stage. A redirect from the core (taken branch or jump) flushes all buffered and in-flight instructions and restarts fetching at the redirect target.

---
 rtl/instr_prefetch_queue.sv | 154 +++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
//   Sequential instruction prefetcher between the instruction memory port and the
//   fetch stage. Keeps at most one memory request in flight, buffers up to DEPTH
//   returned {instr, pc} pairs in a circular queue and presents them in order.
//   A redirect flushes the queue and restarts fetching at the new target. A response
//   that is still in flight at the redirect is discarded when it returns.
//
// Ports
//   clk, reset        core clock; asynchronous active-high reset
//   ImemReq/ImemAdr   fetch request valid / word-aligned byte address
//   ImemValid/ImemRd  response valid (oldest outstanding request) / instruction word
//   InstrValidF       head entry valid; InstrF/PCF are its instruction and PC
//                     (NOP / 0 when not valid)
//   StallF            fetch stage holds the head this cycle
//   Redirect          flush and restart fetch at RedirectPC (bits [1:0] ignored)
//
// Configuration
//   IFQ_BYPASS_EN     when defined, a response arriving at an empty queue is forwarded
//                     combinationally to InstrF/PCF in the same cycle.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReq,
  output logic [31:0] ImemAdr,
  input  logic        ImemValid,
  input  logic [31:0] ImemRd,
  output logic        InstrValidF,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  input  logic        StallF,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC
);

  localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW     = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [31:0]     NopInstr = 32'h0000_0013;

  logic [31:0]     r_instr [DEPTH];
  logic [31:0]     r_pc    [DEPTH];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_count;
  logic [31:0]     r_fpc;
  logic [31:0]     r_req_pc;   // PC of the request currently in flight
  logic            r_inflight;
  logic            r_drop;     // in-flight response belongs to a flushed stream

  logic            w_resp;
  logic            w_head_valid;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic [CntW-1:0] w_occ;
  logic            w_unused;

  assign w_unused     = ^RedirectPC[1:0];
  assign w_resp       = ImemValid & r_inflight;  // responses with nothing in flight are ignored
  assign w_head_valid = (r_count != '0);

  // Occupancy counts the in-flight word so a returning response always has a slot.
  // A new request may only go out when nothing is in flight or the in-flight word
  // returns this cycle; this also holds off the target fetch until a stale word returns.
  assign w_occ   = r_count + CntW'(r_inflight);
  assign w_issue = ~reset & ~Redirect & (w_occ < DepthCnt) & (~r_inflight | ImemValid);

  assign ImemReq = w_issue;
  assign ImemAdr = r_fpc;
  assign w_pop   = w_head_valid & ~StallF;

`ifdef IFQ_BYPASS_EN
  logic w_bypass;
  assign w_bypass = ~w_head_valid & w_resp & ~r_drop & ~Redirect;
  // A bypassed word consumed this cycle never enters the queue.
  assign w_push   = w_resp & ~r_drop & ~Redirect & ~(w_bypass & ~StallF);
`else
  assign w_push   = w_resp & ~r_drop & ~Redirect;
`endif

  always_comb begin
    InstrValidF = w_head_valid;
    InstrF      = w_head_valid ? r_instr[r_rd_ptr] : NopInstr;
    PCF         = w_head_valid ? r_pc[r_rd_ptr]    : 32'h0;
`ifdef IFQ_BYPASS_EN
    if (w_bypass) begin
      InstrValidF = 1'b1;
      InstrF      = ImemRd;
      PCF         = r_req_pc;
    end
`endif
  end

  // Queue storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= ImemRd;
      r_pc[r_wr_ptr]    <= r_req_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_fpc      <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
    end else if (Redirect) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_fpc      <= {RedirectPC[31:2], 2'b00};
      // A word returning in the redirect cycle is simply discarded; one still
      // outstanding must be dropped when it arrives.
      r_inflight <= r_inflight & ~ImemValid;
      r_drop     <= r_inflight & ~ImemValid;
    end else begin
      if (w_issue) begin
        r_fpc    <= r_fpc + 32'd4;
        r_req_pc <= r_fpc;
      end

      if (w_issue) begin
        r_inflight <= 1'b1;
      end else if (w_resp) begin
        r_inflight <= 1'b0;
      end

      if (w_resp && r_drop) begin
        r_drop <= 1'b0;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue (default build, DEPTH=4, RESET_PC=0).
// A small memory model returns mem_word(addr) a programmable number of cycles after
// each accepted request. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
module tb_instr_prefetch_queue;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        ImemReq;
  logic [31:0] ImemAdr;
  logic        ImemValid;
  logic [31:0] ImemRd;
  logic        InstrValidF;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        StallF;
  logic        Redirect;
  logic [31:0] RedirectPC;

  instr_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ImemReq     (ImemReq),
    .ImemAdr     (ImemAdr),
    .ImemValid   (ImemValid),
    .ImemRd      (ImemRd),
    .InstrValidF (InstrValidF),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .StallF      (StallF),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Memory model state
  int unsigned lat;
  logic        pend;
  logic [31:0] pend_adr;
  int unsigned pend_cnt;
  logic        req_now;
  logic [31:0] adr_now;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input bit exp_valid, input logic [31:0] exp_pc);
    check_eq({tag, "_vld"}, 32'(InstrValidF), 32'(exp_valid));
    if (exp_valid) begin
      check_eq({tag, "_pc"}, PCF, exp_pc);
      check_eq({tag, "_ins"}, InstrF, mem_word(exp_pc));
    end else begin
      check_eq({tag, "_pc"}, PCF, 32'h0);
      check_eq({tag, "_ins"}, InstrF, Nop);
    end
  endtask

  task automatic check_req(input string tag, input bit exp_req, input logic [31:0] exp_adr);
    check_eq({tag, "_req"}, 32'(ImemReq), 32'(exp_req));
    if (exp_req) check_eq({tag, "_adr"}, ImemAdr, exp_adr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, 32'(ImemReq), 32'd0);
    check_eq({tag, "_adr"}, ImemAdr, 32'h0);
    check_head(tag, 1'b0, 32'h0);
  endtask

  // Called on the falling edge: capture the request, advance to just after the
  // next rising edge and update the memory model.
  task automatic adv();
    req_now = ImemReq;
    adr_now = ImemAdr;
    @(posedge clk);
    #1;
    ImemValid = 1'b0;
    if (req_now) begin
      pend     = 1'b1;
      pend_adr = adr_now;
      pend_cnt = lat;
    end
    if (pend) begin
      if (pend_cnt <= 1) begin
        ImemValid = 1'b1;
        ImemRd    = mem_word(pend_adr);
        pend      = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pend      = 1'b0;
    ImemValid = 1'b0;
    @(negedge clk);
    adv();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    StallF     = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;
    ImemValid  = 1'b0;
    ImemRd     = 32'h0;
    lat        = 1;
    pend       = 1'b0;

    // T1: reset values, then streaming with 1-cycle memory
    @(negedge clk);
    check_reset_outputs("rst");
    adv();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_req($sformatf("t1_c%0d", k), 1'b1, 32'(4 * (k - 1)));
      check_head($sformatf("t1_c%0d", k), k >= 3, 32'(4 * (k - 3)));
      adv();
    end

    // T2: stall from reset fills exactly four entries, then drains in order
    do_reset();
    StallF = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check_req($sformatf("t2_c%0d", k), k <= 4, 32'(4 * (k - 1)));
      check_head($sformatf("t2_c%0d", k), k >= 3, 32'h0);
      adv();
    end
    StallF = 1'b0;
    for (int k = 11; k <= 16; k++) begin
      @(negedge clk);
      if (k == 11) check_req("t2_c11", 1'b0, 32'h0);
      if (k == 12) check_req("t2_c12", 1'b1, 32'd16);
      if (k == 13) check_req("t2_c13", 1'b1, 32'd20);
      check_head($sformatf("t2_c%0d", k), 1'b1, 32'(4 * (k - 11)));
      adv();
    end

    // T3: redirect with a 3-cycle request outstanding; stale word must be dropped
    lat = 3;
    do_reset();
    @(negedge clk);
    check_req("t3_c1", 1'b1, 32'h0);
    adv();
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0102;
    @(negedge clk);
    check_req("t3_c2", 1'b0, 32'h0);
    adv();
    Redirect = 1'b0;
    @(negedge clk);
    check_req("t3_c3", 1'b0, 32'h0);
    check_head("t3_c3", 1'b0, 32'h0);
    adv();
    @(negedge clk);
    check_req("t3_c4", 1'b1, 32'h0000_0100);
    check_head("t3_c4", 1'b0, 32'h0);
    adv();
    for (int k = 5; k <= 6; k++) begin
      @(negedge clk);
      check_req($sformatf("t3_c%0d", k), 1'b0, 32'h0);
      check_head($sformatf("t3_c%0d", k), 1'b0, 32'h0);
      adv();
    end
    @(negedge clk);
    check_req("t3_c7", 1'b1, 32'h0000_0104);
    check_head("t3_c7", 1'b0, 32'h0);
    adv();
    @(negedge clk);
    check_head("t3_c8", 1'b1, 32'h0000_0100);
    adv();

    // T4: redirect coincident with a response and a pop
    lat = 1;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      adv();
    end
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0040;
    @(negedge clk);
    check_req("t4_c5", 1'b0, 32'h0);
    check_head("t4_c5", 1'b1, 32'd8);
    adv();
    Redirect = 1'b0;
    @(negedge clk);
    check_req("t4_c6", 1'b1, 32'h0000_0040);
    check_head("t4_c6", 1'b0, 32'h0);
    adv();
    @(negedge clk);
    check_req("t4_c7", 1'b1, 32'h0000_0044);
    check_head("t4_c7", 1'b0, 32'h0);
    adv();

    // T5: redirect (again coincident with a response) to the top of the address space
    Redirect   = 1'b1;
    RedirectPC = 32'hFFFF_FFF8;
    @(negedge clk);
    check_head("t4_c8", 1'b1, 32'h0000_0040);
    adv();
    Redirect = 1'b0;
    @(negedge clk);
    check_req("t5_c9", 1'b1, 32'hFFFF_FFF8);
    check_head("t5_c9", 1'b0, 32'h0);
    adv();
    @(negedge clk);
    check_req("t5_c10", 1'b1, 32'hFFFF_FFFC);
    check_head("t5_c10", 1'b0, 32'h0);
    adv();
    @(negedge clk);
    check_req("t5_c11", 1'b1, 32'h0000_0000);
    check_head("t5_c11", 1'b1, 32'hFFFF_FFF8);
    adv();
    @(negedge clk);
    check_req("t5_c12", 1'b1, 32'h0000_0004);
    check_head("t5_c12", 1'b1, 32'hFFFF_FFFC);
    adv();
    @(negedge clk);
    check_req("t5_c13", 1'b1, 32'h0000_0008);
    check_head("t5_c13", 1'b1, 32'h0000_0000);
    lat = 2;
    adv();

    // T6: one-cycle reset while the request for 0x8 is pending; it returns after reset
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6_rst");
    adv();
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6_c15_stale_vld", 32'(ImemValid), 32'd1);
    check_req("t6_c15", 1'b1, 32'h0);
    check_head("t6_c15", 1'b0, 32'h0);
    lat = 1;
    adv();
    @(negedge clk);
    check_req("t6_c16", 1'b1, 32'h4);
    check_head("t6_c16", 1'b0, 32'h0);
    adv();
    @(negedge clk);
    check_head("t6_c17", 1'b1, 32'h0);
    adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
